// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//
// Scans a 4x4 matrix keypad for the clock's setting keys. One column is
// driven high at a time. The row response is synchronised and then
// debounced. An accepted key is reported as a 4-bit code,
// {row_idx, col_idx}, together with a single-cycle strobe.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset_n    in   1  synchronous, active-low reset
//   row        in   4  keypad rows, active-high, asynchronous to clk
//   col        out  4  one-hot column drive, active-high
//   key_code   out  4  last accepted key, row_idx*4 + col_idx
//   key_valid  out  1  one-cycle pulse when a new key is accepted
//   key_held   out  1  high from acceptance until a debounced release
//   dbg_state  out  2  FSM state (0 SCAN, 1 DEBOUNCE, 2 PRESSED)
//
// There is no handshake. key_valid is a one-cycle strobe and is not
// back-pressured. A consumer that misses the strobe can still read
// key_code, which holds its value until the next accept.

module keypad_scan_encoder #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_TICKS);
  localparam logic          DEB_ONE   = (DEBOUNCE_TICKS == 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [3:0]    row_m, row_s;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    col_idx, col_idx_d;
  logic [1:0]    row_idx, row_idx_d;
  logic [3:0]    cap_row, cap_row_d;
  logic [DW-1:0] deb_cnt, deb_cnt_d, deb_inc;
  logic [3:0]    key_code_d;
  logic          key_valid_d, key_held_d;
  logic          row_onehot;
  logic [1:0]    row_enc;

  assign tick    = (presc == PRESC_MAX);
  assign deb_inc = deb_cnt + DW'(1);

  // Only a single active row counts as a press. Ghosting from two keys
  // shows up as a multi-bit pattern and is rejected here.
  assign row_onehot = (row_s != 4'b0000) && ((row_s & (row_s - 4'd1)) == 4'b0000);

  always_comb begin
    row_enc = 2'd0;
    case (row_s)
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state;
    col_idx_d   = col_idx;
    row_idx_d   = row_idx;
    cap_row_d   = cap_row;
    deb_cnt_d   = deb_cnt;
    key_code_d  = key_code;
    key_valid_d = 1'b0;
    key_held_d  = key_held;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (row_onehot) begin
            cap_row_d = row_s;
            row_idx_d = row_enc;
            deb_cnt_d = DW'(1);
            if (DEB_ONE) begin
              key_code_d  = {row_enc, col_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == cap_row) begin
            if (deb_inc == DEB_MAX) begin
              key_code_d  = {row_idx, col_idx};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              deb_cnt_d   = '0;
              state_d     = ST_PRESSED;
            end else begin
              deb_cnt_d = deb_inc;
            end
          end else begin
            deb_cnt_d = '0;
            col_idx_d = col_idx + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          // Column stays frozen, so a second key on another row of this
          // column appears as a mismatch and counts towards release.
          if (row_s == cap_row) begin
            deb_cnt_d = '0;
          end else if (deb_inc == DEB_MAX) begin
            deb_cnt_d  = '0;
            key_held_d = 1'b0;
            col_idx_d  = col_idx + 2'd1;
            state_d    = ST_SCAN;
          end else begin
            deb_cnt_d = deb_inc;
          end
        end
        default: begin
          deb_cnt_d = '0;
          state_d   = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_m     <= 4'b0000;
      row_s     <= 4'b0000;
      presc     <= '0;
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cap_row   <= 4'b0000;
      deb_cnt   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      presc     <= tick ? '0 : presc + PW'(1);
      state     <= state_d;
      col_idx   <= col_idx_d;
      row_idx   <= row_idx_d;
      cap_row   <= cap_row_d;
      deb_cnt   <= deb_cnt_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_held  <= key_held_d;
    end
  end

  assign col       = 4'b0001 << col_idx;
  assign dbg_state = state;

endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

Sequential 4x4 matrix-keypad scanner for the clock's setting keys. Drives a one-hot column pattern, samples the one-hot row response, debounces it, and encodes the pressed key into a 4-bit code with a single-cycle valid strobe. It is the receive-side counterpart of the 2-to-4 one-hot decode/encode logic. Its outputs feed the time-setting FSM that sits alongside the FND counter.

## Interface

Parameters:
- `SCAN_CYCLES`, default 100000: clk cycles per scan tick (1 ms at 100 MHz); legal range ≥ 2.
- `DEBOUNCE_TICKS`, default 10: consecutive matching ticks required to accept a press or a release; legal range ≥ 1.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `row` input 4: keypad rows, active-high, pulled low externally, asynchronous to `clk`.
- `col` output 4: one-hot column drive, active-high.
- `key_code` output 4: last accepted key, `{row_idx[1:0], col_idx[1:0]}` = row_idx*4 + col_idx.
- `key_valid` output 1: one-cycle pulse when a new key is accepted.
- `key_held` output 1: level, high from acceptance until debounced release.

## Operation

- **Reset values** (`reset_n` low at an edge): `col`=4'b0001, col_idx=0, `key_code`=0, `key_valid`=0, `key_held`=0, prescaler=0, deb_cnt=0, state=SCAN, synchronizer=0.
- **Reset mid-operation:** any state returns to the reset values at the next edge. No `key_valid` is emitted.
- **Synchronizer:** `row` passes through a 2-flop synchronizer to give row_s. All decisions use row_s only.
- **Prescaler:** counts 0..SCAN_CYCLES-1 and wraps. tick=1 when the count equals SCAN_CYCLES-1. Width is $clog2(SCAN_CYCLES). It free-runs in every state.
- **Column drive:** `col` = decode(col_idx): 0→0001, 1→0010, 2→0100, 3→1000.
- **Row encode:** 0001→0, 0010→1, 0100→2, 1000→3. Only single-bit row_s is a valid press. 0000 and any multi-bit pattern are "no valid key".
- **FSM states and transitions** (state changes happen only on edges where tick=1):
  - **SCAN**
    - If row_s is valid one-hot: capture cap_row=row_s and row_idx, freeze col_idx, set deb_cnt=1.
      - If DEBOUNCE_TICKS==1: go directly to accept.
      - Otherwise: go to DEBOUNCE.
    - Otherwise: col_idx ← col_idx+1 mod 4, so 3 wraps to 0.
  - **DEBOUNCE**
    - row_s==cap_row: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, accept.
    - Mismatch (release, other row, or multi-bit): go to SCAN and advance col_idx. No output change.
  - **Accept:** `key_code` ← {row_idx, col_idx}, `key_valid`=1 for exactly the following cycle, `key_held`=1, deb_cnt=0, state=PRESSED.
  - **PRESSED** (`col` stays frozen)
    - row_s==cap_row: deb_cnt=0.
    - Otherwise: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, set `key_held`=0, advance col_idx, go to SCAN.
- **No auto-repeat.** A second simultaneous key is ignored until the first key is released.
- `key_code` holds its last accepted value until the next accept or reset.

## Timing

- Row-to-decision latency: 2 cycles of synchronization, plus waiting for the next tick.
- Press acceptance: DEBOUNCE_TICKS ticks, counted from the first tick that sees the key, with the column frozen.
- Release: DEBOUNCE_TICKS consecutive non-matching ticks.
- `key_valid` and `key_held` are registered. They change on the edge following a tick decision and are never high outside that rule.
- `key_valid` never asserts in two consecutive cycles.
- Column changes occur only on tick edges. `col` is never all-zero and never multi-hot.

## Test plan

Bench keypad model: row[r] = col[c] && pressed(r,c). Use SCAN_CYCLES=4, DEBOUNCE_TICKS=3.

1. **Reset and idle:** hold `reset_n` low 3 cycles, then release with no key pressed.
   - Required: `col` starts at 0001 and steps 0001→0010→0100→1000→0001, once every 4 cycles.
   - Required: `key_valid`=0 and `key_held`=0 throughout.
2. **Single press:** press key (2,1) and hold.
   - Required: `col` freezes at 0010.
   - Required: after 3 matching ticks, `key_code`=9, `key_valid` high exactly 1 cycle, `key_held`=1.
   - Required: no further pulses while the key is held.
3. **Release:** release key (2,1).
   - Required: `key_held` falls after 3 ticks.
   - Required: `col` resumes at 0100.
   - Required: `key_code` stays 9.
4. **Bounce:** press key (3,3) for 1 tick, release for 1 tick, then hold.
   - Required: no pulse from the bounce.
   - Required: after a stable hold, `key_code`=15 with a single pulse.
   - Then, in PRESSED, drop the row for 2 ticks and restore it. Required: `key_held` stays 1.
5. **Multi-key:** while (0,0) is accepted, also press (1,0).
   - Required: row_s=0011 counts as non-match, so after 3 ticks `key_held`=0.
   - Required: no new pulse while row_s is multi-bit.
6. **Reset mid-debounce:** press (1,2), then assert `reset_n` during the second debounce tick.
   - Required: next cycle `col`=0001, `key_code`=0, `key_valid`=0, `key_held`=0.
